// File: rtl/delay_line_2d_var_if.sv
// Bundle of the delay line's stream, control and status signals.
// The master side drives samples and controls; the slave side is the delay line.
interface delay_line_2d_var_if #(
    parameter int NUM_FEATURES = 4,
    parameter int N            = 4,
    parameter int PRECISION    = 4,
    parameter int MAX_DELAY    = 8
);
    localparam int SEL_W = $clog2(MAX_DELAY + 1);

    logic                                            ce;
    logic                                            flush;
    logic [SEL_W-1:0]                                delay_sel;
    logic                                            i_valid;
    logic [NUM_FEATURES-1:0][N-1:0][PRECISION-1:0]   idata;
    logic                                            o_valid;
    logic [NUM_FEATURES-1:0][N-1:0][PRECISION-1:0]   odata;
    logic                                            o_primed;
    logic                                            o_sel_err;

    modport master (
        output ce, flush, delay_sel, i_valid, idata,
        input  o_valid, odata, o_primed, o_sel_err
    );

    modport slave (
        input  ce, flush, delay_sel, i_valid, idata,
        output o_valid, odata, o_primed, o_sel_err
    );
endinterface

// File: rtl/delay_line_2d_var.sv
// Runtime-selectable delay line for NUM_FEATURES x N x PRECISION feature arrays.
// Delay is counted in ce-advances; the tap is a combinational mux over the stages,
// with tap 0 meaning passthrough. A prime counter reports when the selected tap
// holds only history written since the last flush / select change.
module delay_line_2d_var #(
    parameter int NUM_FEATURES = 4,
    parameter int N            = 4,
    parameter int PRECISION    = 4,
    parameter int MAX_DELAY    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    delay_line_2d_var_if.slave   bus
);
    localparam int SEL_W = $clog2(MAX_DELAY + 1);
    localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(MAX_DELAY);

    typedef logic [NUM_FEATURES-1:0][N-1:0][PRECISION-1:0] array_t;

    typedef struct packed {
        logic   valid;
        array_t data;
    } stage_t;

    stage_t           stage_q [1:MAX_DELAY];
    logic [SEL_W-1:0] prime_cnt_q, prime_cnt_d;
    logic [SEL_W-1:0] prev_eff_q;
    logic             sel_err_q, sel_err_d;
    logic [SEL_W-1:0] eff;
    logic             sel_over;

    // Clamp the requested delay to the deepest stage.
    assign sel_over = (bus.delay_sel > MAX_SEL);
    assign eff      = sel_over ? MAX_SEL : bus.delay_sel;

    // Stage shift register: flush drops valid tags (data kept), ce advances.
    // NOTE: the stage data is reset too, so odata is defined (zero) straight after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= MAX_DELAY; k++) begin
                stage_q[k] <= '0;
            end
        end else if (bus.flush) begin
            for (int k = 1; k <= MAX_DELAY; k++) begin
                stage_q[k].valid <= 1'b0;
            end
        end else if (bus.ce) begin
            // NOTE: non-blocking assignment lets every stage read its neighbour's old value.
            stage_q[1] <= '{valid: bus.i_valid, data: bus.idata};
            for (int k = 2; k <= MAX_DELAY; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    // Next prime count and sticky select-error flag; flush outranks everything.
    always_comb begin
        // NOTE: defaults first so no path leaves a value unassigned (no latch).
        prime_cnt_d = prime_cnt_q;
        sel_err_d   = sel_err_q | sel_over;
        if (bus.flush) begin
            prime_cnt_d = '0;
            sel_err_d   = 1'b0;
        end else if (eff != prev_eff_q) begin
            prime_cnt_d = '0;
        end else if (bus.ce && (prime_cnt_q < MAX_SEL)) begin
            prime_cnt_d = prime_cnt_q + 1'b1;
        end
    end

    // Control registers; the previous select is sampled on every edge, stalled or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prime_cnt_q <= '0;
            prev_eff_q  <= '0;
            sel_err_q   <= 1'b0;
        end else begin
            prime_cnt_q <= prime_cnt_d;
            prev_eff_q  <= eff;
            sel_err_q   <= sel_err_d;
        end
    end

    // Tap mux: eff 0 passes the input through, otherwise read stage eff.
    always_comb begin
        bus.odata   = bus.idata;
        bus.o_valid = bus.i_valid;
        for (int k = 1; k <= MAX_DELAY; k++) begin
            if (eff == SEL_W'(k)) begin
                bus.odata   = stage_q[k].data;
                bus.o_valid = stage_q[k].valid;
            end
        end
    end

    // Primed once enough advances have refilled the selected tap; never during reset.
    assign bus.o_primed  = rst_n & (prime_cnt_q >= eff);
    assign bus.o_sel_err = sel_err_q;

endmodule

// File: tb/tb_delay_line_2d_var.sv
// Self-checking bench for delay_line_2d_var: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// queue-based history model.
module tb_delay_line_2d_var;
    localparam int NUM_FEATURES = 4;
    localparam int N            = 4;
    localparam int PRECISION    = 4;
    localparam int MAX_DELAY    = 8;
    localparam int SEL_W        = $clog2(MAX_DELAY + 1);
    localparam int DW           = NUM_FEATURES * N * PRECISION;

    bit   clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    delay_line_2d_var_if #(
        .NUM_FEATURES(NUM_FEATURES), .N(N), .PRECISION(PRECISION), .MAX_DELAY(MAX_DELAY)
    ) bus ();

    delay_line_2d_var #(
        .NUM_FEATURES(NUM_FEATURES), .N(N), .PRECISION(PRECISION), .MAX_DELAY(MAX_DELAY)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] fill(input int v);
        logic [DW-1:0] r;
        for (int i = 0; i < NUM_FEATURES * N; i++) begin
            r[i*PRECISION +: PRECISION] = PRECISION'(v);
        end
        return r;
    endfunction

    function automatic int eff_of(input logic [SEL_W-1:0] s);
        return (int'(s) > MAX_DELAY) ? MAX_DELAY : int'(s);
    endfunction

    // ---------------- behavioural model ----------------
    // hist[0] is the newest stored sample, hist[k-1] is the one k advances old.
    logic [DW:0] hist[$];
    int          m_cnt;      // advances since last reset/flush/select change, saturated
    int          m_prev;
    bit          m_err;

    always @(posedge clk or negedge rst_n) begin
        int          e;
        logic [DW:0] ent;
        if (!rst_n) begin
            hist = {};
            for (int i = 0; i < MAX_DELAY; i++) hist.push_back('0);
            m_cnt  = 0;
            m_prev = 0;
            m_err  = 0;
        end else begin
            e = eff_of(bus.delay_sel);
            if (bus.flush) begin
                for (int i = 0; i < MAX_DELAY; i++) begin
                    ent     = hist[i];
                    ent[DW] = 1'b0;
                    hist[i] = ent;
                end
                m_cnt = 0;
                m_err = 0;
            end else begin
                if (int'(bus.delay_sel) > MAX_DELAY) m_err = 1;
                if (e != m_prev) m_cnt = 0;
                else if (bus.ce && m_cnt < MAX_DELAY) m_cnt++;
                if (bus.ce) begin
                    hist.push_front({bus.i_valid, bus.idata});
                    void'(hist.pop_back());
                end
            end
            m_prev = e;
        end
    end

    // Every-cycle comparison, sampled midway between rising edges.
    always @(negedge clk) begin
        int          e;
        logic [DW:0] ent;
        logic        ev;
        logic [DW-1:0] ed;
        e = eff_of(bus.delay_sel);
        if (e == 0) begin
            ev = bus.i_valid;
            ed = bus.idata;
        end else begin
            ent = hist[e-1];
            ev  = ent[DW];
            ed  = ent[DW-1:0];
        end
        check("cyc_odata",  bus.odata, ed);
        check("cyc_valid",  DW'(bus.o_valid), DW'(ev));
        check("cyc_primed", DW'(bus.o_primed), DW'(rst_n && (m_cnt >= e)));
        check("cyc_selerr", DW'(bus.o_sel_err), DW'(m_err));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n         = 1'b0;
        bus.ce        = 1'b0;
        bus.flush     = 1'b0;
        bus.delay_sel = SEL_W'(3);
        bus.i_valid   = 1'b0;
        bus.idata     = '0;
        #2;
        check("rst_valid",  DW'(bus.o_valid), DW'(0));
        check("rst_primed", DW'(bus.o_primed), DW'(0));
        check("rst_selerr", DW'(bus.o_sel_err), DW'(0));
        #10 rst_n = 1'b1;
        tick();  // idle edge lets the select settle against the post-reset previous value

        // Fixed delay 3 with a ramp.
        for (int v = 1; v <= 6; v++) begin
            bus.ce = 1'b1; bus.i_valid = 1'b1; bus.idata = fill(v);
            tick();
            if (v == 2) begin
                check("fix_valid_early",  DW'(bus.o_valid), DW'(0));
                check("fix_primed_early", DW'(bus.o_primed), DW'(0));
            end
            if (v == 3) begin
                check("fix_first_data", bus.odata, fill(1));
                check("fix_primed",     DW'(bus.o_primed), DW'(1));
            end
            if (v == 5) check("fix_data_5", bus.odata, fill(3));
        end

        // Stall at delay 2.
        bus.delay_sel = SEL_W'(2);
        bus.idata = fill(10); tick();
        bus.idata = fill(11); tick();
        check("stall_a", bus.odata, fill(10));
        bus.ce = 1'b0; bus.idata = fill(12);
        repeat (5) tick();
        check("stall_hold", bus.odata, fill(10));
        bus.ce = 1'b1; bus.idata = fill(13); tick();
        check("stall_b", bus.odata, fill(11));

        // Flush mid-stream at delay 4.
        bus.delay_sel = SEL_W'(4);
        for (int v = 1; v <= 6; v++) begin
            bus.idata = fill(v); tick();
        end
        bus.flush = 1'b1; bus.idata = fill(7); tick();
        bus.flush = 1'b0;
        check("flush_valid",  DW'(bus.o_valid), DW'(0));
        check("flush_primed", DW'(bus.o_primed), DW'(0));
        for (int v = 8; v <= 11; v++) begin
            bus.idata = fill(v); tick();
            if (v == 10) check("flush_valid_3", DW'(bus.o_valid), DW'(0));
        end
        check("flush_first", bus.odata, fill(8));
        check("flush_primed_back", DW'(bus.o_primed), DW'(1));

        // Runtime select change 5 -> 2.
        bus.delay_sel = SEL_W'(5);
        for (int v = 1; v <= 10; v++) begin
            bus.idata = fill(v); tick();
        end
        bus.delay_sel = SEL_W'(2);
        #1;
        check("sel_jump",   bus.odata, fill(9));
        for (int v = 11; v <= 13; v++) begin
            bus.idata = fill(v); tick();
            if (v == 11) check("sel_primed_drop", DW'(bus.o_primed), DW'(0));
            if (v == 13) check("sel_primed_rise", DW'(bus.o_primed), DW'(1));
        end
        check("sel_data", bus.odata, fill(12));

        // Passthrough and overflow.
        bus.ce = 1'b0; bus.delay_sel = '0; bus.i_valid = 1'b0; bus.idata = fill(5);
        #1;
        check("pass_data",   bus.odata, fill(5));
        check("pass_valid",  DW'(bus.o_valid), DW'(0));
        check("pass_primed", DW'(bus.o_primed), DW'(1));
        bus.delay_sel = SEL_W'(MAX_DELAY + 1);
        #1;
        check("ovf_tap",    bus.odata, fill(6));
        check("ovf_no_err", DW'(bus.o_sel_err), DW'(0));
        tick();
        check("ovf_err",    DW'(bus.o_sel_err), DW'(1));
        bus.delay_sel = SEL_W'(3); tick();
        check("ovf_sticky", DW'(bus.o_sel_err), DW'(1));
        bus.flush = 1'b1; tick();
        bus.flush = 1'b0;
        check("ovf_clear",  DW'(bus.o_sel_err), DW'(0));

        // Async reset while streaming at delay 3.
        bus.ce = 1'b1; bus.i_valid = 1'b1; bus.idata = fill(1);
        bus.delay_sel = SEL_W'(12); tick();
        bus.delay_sel = SEL_W'(3);
        for (int v = 2; v <= 5; v++) begin
            bus.idata = fill(v); tick();
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid",  DW'(bus.o_valid), DW'(0));
        check("arst_selerr", DW'(bus.o_sel_err), DW'(0));
        check("arst_primed", DW'(bus.o_primed), DW'(0));
        #2 rst_n = 1'b1;
        bus.ce = 1'b0; tick();
        bus.ce = 1'b1;
        for (int v = 7; v <= 9; v++) begin
            bus.idata = fill(v); tick();
            if (v == 8) check("arst_refill_early", DW'(bus.o_valid), DW'(0));
        end
        check("arst_refill", bus.odata, fill(7));

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            bus.ce      = ($urandom_range(0, 3) != 0);
            bus.flush   = ($urandom_range(0, 19) == 0);
            bus.i_valid = $urandom_range(0, 1) == 1;
            bus.idata   = {$urandom, $urandom};
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 9) != 0) bus.delay_sel = SEL_W'($urandom_range(0, MAX_DELAY));
                else bus.delay_sel = SEL_W'($urandom_range(MAX_DELAY + 1, (1 << SEL_W) - 1));
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/delay_line_2d_var.md
Name: delay_line_2d_var

Overview:
- Runtime-selectable delay line for 2D feature arrays of shape NUM_FEATURES x N x PRECISION.
- Supersedes the fixed-delay buffer in the pipeline: it aligns feature tensors against variable-latency branches.
- Adds a valid tag, clock-enable stall, flush, and a primed indicator.
- The tap point is chosen at run time from 0..MAX_DELAY.

Parameters:
- NUM_FEATURES, 4, outer array dimension.
- N, 4, inner array dimension.
- PRECISION, 4, bits per element.
- MAX_DELAY, 8, deepest selectable delay in ce-advances; legal range >= 1.
- SEL_W, $clog2(MAX_DELAY+1), width of delay_sel and the internal prime counter. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ce  in  1  advance enable; when low, all state holds.
- flush  in  1  synchronous invalidate of all stored samples.
- delay_sel  in  SEL_W  requested delay in ce-advances.
- i_valid  in  1  idata qualifier.
- idata  in  [PRECISION-1:0] x [NUM_FEATURES][N]  input array.
- o_valid  out  1  odata qualifier.
- odata  out  [PRECISION-1:0] x [NUM_FEATURES][N]  delayed array.
- o_primed  out  1  high once the selected tap holds only post-flush, post-select history.
- o_sel_err  out  1  sticky flag: delay_sel > MAX_DELAY was seen.

Behaviour:
- Storage: stages S[1..MAX_DELAY], each holding {valid, data}.
- Reset (rst_n low, asynchronous):
  - all S data = 0, all S valid = 0;
  - prime counter = 0, registered previous sel = 0, o_sel_err = 0.
  - odata/o_valid then follow the tap rules below; with delay_sel=0 they pass the input through.
- Shift, on posedge with ce=1 and flush=0: S[1] <= {i_valid, idata}; S[k] <= S[k-1] for k = 2..MAX_DELAY.
- ce=0 and flush=0: every register holds. Stalls do not add delay; delay is counted in ce-advances, not cycles.
- Flush (any ce): on the next edge, all S valid = 0 and the prime counter = 0. S data is retained.
  - The input presented in the flush cycle is discarded.
  - Flush has priority over ce.
- Effective select: eff = min(delay_sel, MAX_DELAY). If delay_sel > MAX_DELAY, o_sel_err sets on the next edge and stays set until flush or reset.
- Tap (combinational mux, no extra latency):
  - eff = 0: odata = idata, o_valid = i_valid (passthrough, independent of ce).
  - eff = k >= 1: odata = S[k].data, o_valid = S[k].valid.
- Delay change: the tap moves in the same cycle delay_sel changes. No data is lost or duplicated inside the stages; only the observed tap differs.
- Prime counter, updated per edge in this priority order:
  - reset or flush -> 0;
  - eff differs from the registered previous eff -> 0;
  - ce=1 -> increment, saturating at MAX_DELAY;
  - otherwise hold.
  - Previous eff is registered every cycle.
- o_primed = (counter >= eff), combinational. eff = 0 gives o_primed = 1 at all times except during reset.
- Total latency for eff = k is exactly k ce-advances. With ce held high, a sample taken at edge t appears on odata after edge t+k-1, i.e. in the cycle following k rising edges.
- All outputs are glitch-free registered values except the tap mux and o_primed compare, which are combinational from registers and delay_sel.

Test Plan:
- Reset then fixed delay: rst_n pulse, delay_sel=3, ce=1, i_valid=1, idata all elements = cycle index 1,2,3...
  -> o_valid=0 and o_primed=0 until 3 edges have passed; then odata = value injected 3 edges earlier; o_primed=1 from the 3rd edge.
- Stall: delay_sel=2, inject A,B; drop ce for 5 cycles; inject C.
  -> odata holds A through the stall; B appears after the first ce edge following the stall; no valid pulse is duplicated.
- Flush mid-stream: delay_sel=4, stream 6 valid samples, assert flush for one cycle with ce=1.
  -> the next edge gives o_valid=0 and o_primed=0; the flush-cycle input never appears; the first post-flush sample emerges 4 edges later.
- Runtime select change: stream a ramp at delay_sel=5, switch to 2.
  -> odata jumps to the sample 2 back in the same cycle; o_primed drops for 2 edges, then rises.
- Passthrough and overflow: delay_sel=0 -> odata==idata and o_valid==i_valid combinationally, o_primed=1. Then delay_sel=MAX_DELAY+1
  -> tap = S[MAX_DELAY]; o_sel_err=1 after the next edge; it stays 1 after delay_sel returns legal and clears on flush.
- Async reset mid-operation: drop rst_n between edges while streaming at delay_sel=3.
  -> o_valid=0, o_sel_err=0, o_primed=0 immediately, without waiting for clk; after release, refill takes 3 edges.
